// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified-memory data-port arbiter family:
// owner-state encoding, default bus widths and a small state helper.
package mem_arb_pkg;

    // Default byte-address and data widths of the memory data port.
    localparam int AW_DEF = 16;
    localparam int DW_DEF = 16;

    // Who currently owns the memory data port.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } owner_t;

    // Map a picker winner index onto the matching ownership state.
    function automatic owner_t owner_of(input logic winner);
        return winner ? OWN1 : OWN0;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the two requester handshakes (CPU = r0, loader/DMA = r1) and
// the memory data-port signals. The arbiter takes the slave view; the
// requesters and the memory model sit on the master view.
interface mem_port_arbiter_if #(
    parameter int AW = mem_arb_pkg::AW_DEF,
    parameter int DW = mem_arb_pkg::DW_DEF
);
    // Requester 0: CPU load/store path.
    logic          r0_req;
    logic          r0_lock;
    logic          r0_we;
    logic [AW-1:0] r0_addr;
    logic [DW-1:0] r0_wdata;
    logic          r0_gnt;
    logic          r0_rvalid;
    logic [DW-1:0] r0_rdata;

    // Requester 1: external loader / DMA master.
    logic          r1_req;
    logic          r1_lock;
    logic          r1_we;
    logic [AW-1:0] r1_addr;
    logic [DW-1:0] r1_wdata;
    logic          r1_gnt;
    logic          r1_rvalid;
    logic [DW-1:0] r1_rdata;

    // Memory data port; read data arrives the cycle after the address.
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_save;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  r0_req, r0_lock, r0_we, r0_addr, r0_wdata,
        output r0_gnt, r0_rvalid, r0_rdata,
        input  r1_req, r1_lock, r1_we, r1_addr, r1_wdata,
        output r1_gnt, r1_rvalid, r1_rdata,
        output mem_addr, mem_wdata, mem_save,
        input  mem_rdata
    );

    modport master (
        output r0_req, r0_lock, r0_we, r0_addr, r0_wdata,
        input  r0_gnt, r0_rvalid, r0_rdata,
        output r1_req, r1_lock, r1_we, r1_addr, r1_wdata,
        input  r1_gnt, r1_rvalid, r1_rdata,
        input  mem_addr, mem_wdata, mem_save,
        output mem_rdata
    );

endinterface

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker: the requester that did not
// win last time has priority; otherwise the other one; valid when anyone
// asks at all.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       valid,
    output logic       winner
);

    logic pref;

    // Prefer the requester that was not served last.
    always_comb begin
        // NOTE: every output gets a default before any branch, so no latch can be inferred.
        valid  = |req;
        pref   = ~last;
        winner = 1'b0;
        if (req[pref]) begin
            winner = pref;
        end else if (req[last]) begin
            winner = last;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the unified memory data port between the CPU (r0) and the
// loader/DMA master (r1). Ownership is registered and re-decided every
// edge; an owner may lock the port for a bounded burst. Read data returns
// one cycle after a granted read, steered to the requester that issued it.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW        = AW_DEF,
    parameter int DW        = DW_DEF,
    parameter int BURST_MAX = 8,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus,
    output logic [CNT_W-1:0]  stall_count
);

    // Burst counter only needs to reach BURST_MAX-1.
    localparam int                HOLD_W    = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(BURST_MAX - 1);

    owner_t            owner;
    owner_t            owner_nxt;
    logic              last;
    logic              last_nxt;
    logic [HOLD_W-1:0] hold;
    logic [HOLD_W-1:0] hold_nxt;
    logic              rv0;
    logic              rv1;

    logic              gnt0;
    logic              gnt1;
    logic              keep;
    logic              pick_valid;
    logic              pick_winner;
    logic              stalled;

    rr_pick2 u_pick (
        .req    ({bus.r1_req, bus.r0_req}),
        .last   (last),
        .valid  (pick_valid),
        .winner (pick_winner)
    );

    // Grants follow registered ownership; mem_rdata never feeds them.
    always_comb begin
        gnt0 = (owner == OWN0) & bus.r0_req;
        gnt1 = (owner == OWN1) & bus.r1_req;
    end

    // Memory port mux: the owner drives address/data; IDLE drives zeros.
    always_comb begin
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_save  = 1'b0;
        case (owner)
            OWN0: begin
                bus.mem_addr  = bus.r0_addr;
                bus.mem_wdata = bus.r0_wdata;
                bus.mem_save  = gnt0 & bus.r0_we;
            end
            OWN1: begin
                bus.mem_addr  = bus.r1_addr;
                bus.mem_wdata = bus.r1_wdata;
                bus.mem_save  = gnt1 & bus.r1_we;
            end
            default: begin
                bus.mem_addr  = '0;
                bus.mem_wdata = '0;
                bus.mem_save  = 1'b0;
            end
        endcase
    end

    // Next owner: keep a locked burst until it reaches BURST_MAX grants,
    // otherwise let the round-robin picker choose (or fall back to IDLE).
    always_comb begin
        owner_nxt = owner;
        last_nxt  = last;
        hold_nxt  = '0;
        case (owner)
            OWN0:    keep = bus.r0_req & bus.r0_lock & (hold < HOLD_LAST);
            OWN1:    keep = bus.r1_req & bus.r1_lock & (hold < HOLD_LAST);
            default: keep = 1'b0;
        endcase

        if (keep) begin
            hold_nxt = hold + 1'b1;
        end else if (pick_valid) begin
            owner_nxt = owner_of(pick_winner);
            last_nxt  = pick_winner;
        end else begin
            owner_nxt = IDLE;
        end
    end

    // Ownership state register; last=1 so the CPU wins the first tie.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
            owner <= IDLE;
            last  <= 1'b1;
            hold  <= '0;
        end else begin
            owner <= owner_nxt;
            last  <= last_nxt;
            hold  <= hold_nxt;
        end
    end

    // Remember which requester issued a read, to steer the returning data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rv0 <= 1'b0;
            rv1 <= 1'b0;
        end else begin
            rv0 <= gnt0 & ~bus.r0_we;
            rv1 <= gnt1 & ~bus.r1_we;
        end
    end

    // A cycle stalls when some requester is asking but not being served.
    always_comb begin
        stalled = (bus.r0_req & ~gnt0) | (bus.r1_req & ~gnt1);
    end

    // Saturating stall counter; holds at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_count <= '0;
        end else if (stalled && (stall_count != '1)) begin
            stall_count <= stall_count + 1'b1;
        end
    end

    // Requester-facing outputs; read data is zero unless it is valid.
    always_comb begin
        bus.r0_gnt    = gnt0;
        bus.r1_gnt    = gnt1;
        bus.r0_rvalid = rv0;
        bus.r1_rvalid = rv1;
        bus.r0_rdata  = rv0 ? bus.mem_rdata : '0;
        bus.r1_rdata  = rv1 ? bus.mem_rdata : '0;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by
// constrained-random traffic, all compared against a cycle-level reference
// model of the ownership rules and a model copy of the memory contents.
module tb_mem_port_arbiter;

    localparam int AW        = 16;
    localparam int DW        = 16;
    localparam int BURST_MAX = 8;
    localparam int CNT_W     = 4;
    localparam int STALL_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [CNT_W-1:0] stall_count;

    mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    mem_port_arbiter #(
        .AW        (AW),
        .DW        (DW),
        .BURST_MAX (BURST_MAX),
        .CNT_W     (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus.slave),
        .stall_count (stall_count)
    );

    always #5 clk = ~clk;

    // Memory behind the data port: one-cycle read latency, word addressed.
    logic [DW-1:0] tb_mem [256] = '{8: 16'hBEEF, default: 16'h0000};
    always @(posedge clk) begin
        if (bus.mem_save) tb_mem[bus.mem_addr[8:1]] <= bus.mem_wdata;
        bus.mem_rdata <= tb_mem[bus.mem_addr[8:1]];
    end

    // Bookkeeping.
    int n_checks = 0;
    int n_pass   = 0;

    // Stimulus for both requesters.
    logic          d_req   [2];
    logic          d_lock  [2];
    logic          d_we    [2];
    logic [AW-1:0] d_addr  [2];
    logic [DW-1:0] d_wdata [2];
    logic          pending [2];

    // Reference model state.
    int            m_own;            // -1 = nobody, else requester index
    int            m_last;
    int            m_run;            // grants in the current ownership run
    int            m_stall;
    logic          m_rv [2];
    logic [DW-1:0] m_rd [2];
    logic [DW-1:0] m_mem [256] = '{8: 16'hBEEF, default: 16'h0000};

    // Observed outputs from the most recent cycle.
    logic             o_g  [2];
    logic             o_rv [2];
    logic [DW-1:0]    o_rd [2];
    logic [AW-1:0]    o_addr;
    logic             o_save;
    logic [CNT_W-1:0] o_stall;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < 2; i++) begin
            d_req[i] = 1'b0; d_lock[i] = 1'b0; d_we[i] = 1'b0;
            d_addr[i] = '0;  d_wdata[i] = '0;  pending[i] = 1'b0;
        end
    endtask

    task automatic drive();
        bus.r0_req = d_req[0]; bus.r0_lock = d_lock[0]; bus.r0_we = d_we[0];
        bus.r0_addr = d_addr[0]; bus.r0_wdata = d_wdata[0];
        bus.r1_req = d_req[1]; bus.r1_lock = d_lock[1]; bus.r1_we = d_we[1];
        bus.r1_addr = d_addr[1]; bus.r1_wdata = d_wdata[1];
    endtask

    task automatic model_reset();
        m_own = -1; m_last = 1; m_run = 0; m_stall = 0;
        for (int i = 0; i < 2; i++) begin
            m_rv[i] = 1'b0; m_rd[i] = '0;
        end
    endtask

    // One clock cycle starting at a falling edge: apply inputs, compare,
    // optionally pulse reset mid-cycle, else step the model to the next edge.
    task automatic cycle(input bit do_rst);
        logic          e_g [2];
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wdata;
        logic          e_save;
        int            pref;
        drive();
        #1;
        e_g[0]  = (m_own == 0) && d_req[0];
        e_g[1]  = (m_own == 1) && d_req[1];
        e_addr  = (m_own >= 0) ? d_addr[m_own]  : '0;
        e_wdata = (m_own >= 0) ? d_wdata[m_own] : '0;
        e_save  = (e_g[0] && d_we[0]) || (e_g[1] && d_we[1]);

        check("r0_gnt",      32'(bus.r0_gnt),    32'(e_g[0]));
        check("r1_gnt",      32'(bus.r1_gnt),    32'(e_g[1]));
        check("mem_addr",    32'(bus.mem_addr),  32'(e_addr));
        check("mem_wdata",   32'(bus.mem_wdata), 32'(e_wdata));
        check("mem_save",    32'(bus.mem_save),  32'(e_save));
        check("r0_rvalid",   32'(bus.r0_rvalid), 32'(m_rv[0]));
        check("r1_rvalid",   32'(bus.r1_rvalid), 32'(m_rv[1]));
        check("r0_rdata",    32'(bus.r0_rdata),  32'(m_rv[0] ? m_rd[0] : '0));
        check("r1_rdata",    32'(bus.r1_rdata),  32'(m_rv[1] ? m_rd[1] : '0));
        check("stall_count", 32'(stall_count),   32'(m_stall));

        o_g[0] = bus.r0_gnt;     o_g[1] = bus.r1_gnt;
        o_rv[0] = bus.r0_rvalid; o_rv[1] = bus.r1_rvalid;
        o_rd[0] = bus.r0_rdata;  o_rd[1] = bus.r1_rdata;
        o_addr = bus.mem_addr;   o_save = bus.mem_save; o_stall = stall_count;

        if (do_rst) begin
            #1 rst = 1'b0;
            #1;
            check("rst_gnt",    32'({bus.r0_gnt, bus.r1_gnt}),       32'(0));
            check("rst_save",   32'(bus.mem_save),                    32'(0));
            check("rst_addr",   32'(bus.mem_addr),                    32'(0));
            check("rst_rvalid", 32'({bus.r0_rvalid, bus.r1_rvalid}), 32'(0));
            check("rst_rdata",  {bus.r0_rdata, bus.r1_rdata},        32'(0));
            check("rst_stall",  32'(stall_count),                     32'(0));
            model_reset();
            for (int i = 0; i < 2; i++) pending[i] = d_req[i];
            @(negedge clk);
            rst = 1'b1;
        end else begin
            if (((d_req[0] && !e_g[0]) || (d_req[1] && !e_g[1])) && m_stall < STALL_MAX)
                m_stall++;
            for (int i = 0; i < 2; i++) begin
                m_rv[i] = e_g[i] && !d_we[i];
                if (m_rv[i]) m_rd[i] = m_mem[d_addr[i][8:1]];
                if (e_g[i] && d_we[i]) m_mem[d_addr[i][8:1]] = d_wdata[i];
                pending[i] = d_req[i] && !e_g[i];
            end
            if (m_own >= 0 && d_req[m_own] && d_lock[m_own] && m_run < BURST_MAX) begin
                m_run++;
            end else begin
                pref = 1 - m_last;
                if (d_req[pref])          m_own = pref;
                else if (d_req[1 - pref]) m_own = 1 - pref;
                else                      m_own = -1;
                if (m_own >= 0) begin
                    m_last = m_own;
                    m_run  = 1;
                end else begin
                    m_run = 0;
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_grant(input int idx, input int max_cycles, input string tag);
        bit got = 1'b0;
        for (int k = 0; k < max_cycles && !got; k++) begin
            cycle(1'b0);
            got = o_g[idx];
        end
        check(tag, 32'(got), 32'(1));
    endtask

    // New random transactions, holding any request not yet granted.
    task automatic gen_random();
        for (int i = 0; i < 2; i++) begin
            if (!pending[i]) begin
                d_req[i]   = ($urandom_range(0, 3) != 0);
                d_we[i]    = 1'($urandom_range(0, 1));
                d_addr[i]  = 16'($urandom_range(0, 511));
                d_wdata[i] = 16'($urandom);
            end
            d_lock[i] = ($urandom_range(0, 2) == 0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit e0, e1;
        clear_inputs();
        drive();
        model_reset();

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("reset_gnt",    32'({bus.r0_gnt, bus.r1_gnt, bus.mem_save}), 32'(0));
        check("reset_rvalid", 32'({bus.r0_rvalid, bus.r1_rvalid}),       32'(0));
        check("reset_stall",  32'(stall_count),                           32'(0));
        rst = 1'b1;
        @(negedge clk);

        // Lone CPU read of 0x0010 returning 0xBEEF.
        d_req[0] = 1'b1; d_addr[0] = 16'h0010; d_we[0] = 1'b0;
        cycle(1'b0);
        check("a_idle_no_gnt", 32'(o_g[0]), 32'(0));
        cycle(1'b0);
        check("a_gnt",  32'(o_g[0]),  32'(1));
        check("a_addr", 32'(o_addr),  32'(16'h0010));
        check("a_save", 32'(o_save),  32'(0));
        d_req[0] = 1'b0;
        cycle(1'b0);
        check("a_rvalid",   32'(o_rv[0]), 32'(1));
        check("a_rdata",    32'(o_rd[0]), 32'(16'hBEEF));
        check("a_r1_quiet", 32'(o_rv[1]), 32'(0));
        cycle(1'b0);

        // Write isolation and read-back.
        d_req[0] = 1'b1; d_we[0] = 1'b1; d_addr[0] = 16'h0020; d_wdata[0] = 16'h1234;
        wait_grant(0, 4, "b_wr_grant");
        check("b_save", 32'(o_save), 32'(1));
        d_req[0] = 1'b0; d_we[0] = 1'b0;
        cycle(1'b0);
        check("b_no_rvalid", 32'(o_rv[0]), 32'(0));
        check("b_save_once", 32'(o_save),  32'(0));
        d_req[0] = 1'b1;
        wait_grant(0, 4, "b_rd_grant");
        d_req[0] = 1'b0;
        cycle(1'b0);
        check("b_rd_rvalid", 32'(o_rv[0]), 32'(1));
        check("b_readback",  32'(o_rd[0]), 32'(16'h1234));

        // Simultaneous unlocked reads from IDLE after reset alternate.
        clear_inputs();
        cycle(1'b1);
        d_req[0] = 1'b1; d_addr[0] = 16'h0040;
        d_req[1] = 1'b1; d_addr[1] = 16'h0042;
        for (int c = 0; c < 8; c++) begin
            cycle(1'b0);
            e0 = (c >= 1) && (c % 2 == 1);
            e1 = (c >= 2) && (c % 2 == 0);
            check("c_alt_r0",   32'(o_g[0]),  32'(e0));
            check("c_alt_r1",   32'(o_g[1]),  32'(e1));
            check("c_stall_up", 32'(o_stall), 32'(c));
        end

        // Locked loader write burst with the CPU waiting.
        clear_inputs();
        cycle(1'b1);
        d_req[1] = 1'b1; d_lock[1] = 1'b1; d_we[1] = 1'b1;
        d_addr[1] = 16'h0100; d_wdata[1] = 16'($urandom);
        for (int c = 0; c < 11; c++) begin
            if (c == 1) begin
                d_req[0] = 1'b1; d_addr[0] = 16'h0030;
            end
            cycle(1'b0);
            e1 = ((c >= 1) && (c <= 8)) || (c == 10);
            e0 = (c == 9);
            check("d_burst_r1", 32'(o_g[1]), 32'(e1));
            check("d_burst_r0", 32'(o_g[0]), 32'(e0));
            check("d_save",     32'(o_save), 32'(e1));
            if (c == 8) check("d_last_addr", 32'(o_addr), 32'(16'h010E));
            if (e1) begin
                d_addr[1]  = d_addr[1] + 16'd2;
                d_wdata[1] = 16'($urandom);
            end
        end

        // Async reset in the middle of a locked loader read burst.
        clear_inputs();
        cycle(1'b1);
        d_req[1] = 1'b1; d_lock[1] = 1'b1; d_we[1] = 1'b0; d_addr[1] = 16'h0050;
        cycle(1'b0);
        cycle(1'b0);
        cycle(1'b1);
        check("e_pre_gnt",    32'(o_g[1]),  32'(1));
        check("e_pre_rvalid", 32'(o_rv[1]), 32'(1));
        d_lock[1] = 1'b0;
        d_req[0] = 1'b1; d_addr[0] = 16'h0060;
        cycle(1'b0);
        check("e_idle_r0", 32'(o_g[0]), 32'(0));
        cycle(1'b0);
        check("e_tie_r0", 32'(o_g[0]), 32'(1));
        check("e_tie_r1", 32'(o_g[1]), 32'(0));

        // Stall counter saturation.
        clear_inputs();
        cycle(1'b1);
        d_req[0] = 1'b1; d_lock[0] = 1'b1; d_addr[0] = 16'h0070;
        d_req[1] = 1'b1; d_addr[1] = 16'h0072;
        for (int c = 0; c < 40; c++) begin
            cycle(1'b0);
            check("f_sat", 32'(o_stall), 32'((c < STALL_MAX) ? c : STALL_MAX));
        end

        // Constrained-random traffic with occasional mid-cycle resets.
        clear_inputs();
        cycle(1'b1);
        for (int n = 0; n < 800; n++) begin
            gen_random();
            cycle($urandom_range(0, 99) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
